fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
- Next-generation synchronous FIFO: control logic plus storage in one block.
- Generalised in data width and depth.
- Adds:
  - occupancy count
  - programmable almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags
  - show-ahead read data
  - push and pop both accepted when full
- Used as the standard single-clock buffer between producer and consumer blocks (e.g. UART RX/TX paths, command queues).

Parameters:
- DATA_WIDTH, 8: width of wdata/rdata in bits (>=1).
- DEPTH, 4: number of entries; power of two, >=2.
- AF_LEVEL, DEPTH-1: almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 1: almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  write request; wdata captured on the edge when accepted.
- pop  in  1  read request; current rdata is consumed on the edge when accepted.
- wdata  in  DATA_WIDTH  write data.
- clr_err  in  1  clears overflow/underflow (synchronous).
- rdata  out  DATA_WIDTH  head-of-queue data (show-ahead); 0 when empty.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (rst=1 at rising edge):
  - wptr=0, rptr=0, count=0, empty=1, full=0, almost_full=0, almost_empty=1, overflow=0, underflow=0.
  - rdata=0. Memory contents are not reset.
  - Reset mid-operation discards all queued data; push/pop in the reset cycle are ignored.
- Pointers: $clog2(DEPTH) bits each, natural wrap DEPTH-1 -> 0. count is a separate register, $clog2(DEPTH)+1 bits wide.
- Acceptance, evaluated on registered state before the edge:
  - push_ok = push & (!full | pop).
  - pop_ok = pop & !empty.
- Per-edge update:
  - push_ok: mem[wptr] <= wdata; wptr += 1.
  - pop_ok: rptr += 1.
  - count: +1 if push_ok only; -1 if pop_ok only; unchanged if both or neither.
- Boundary cases:
  - Full + push + pop: both accepted. The head is read out and the new word is written into the freed slot (wptr == rptr; the write lands on the same edge the old head is consumed). count stays DEPTH.
  - Empty + push + pop: push accepted, pop rejected, underflow set. count -> 1. No bypass: pushed data appears on rdata the next cycle.
  - Full + push only: push rejected, overflow set, memory and pointers unchanged.
  - Empty + pop only: rejected, underflow set.
- Error flags:
  - overflow/underflow stay set until clr_err=1 or reset.
  - If clr_err and a new error occur in the same cycle, the new error wins (flag = 1).
- Output timing:
  - full, empty, almost_full, almost_empty are decoded from the registered count only; no combinational path from push/pop to any flag.
  - Flags update the cycle after the causing edge.
- Read data:
  - rdata = empty ? 0 : mem[rptr], combinational from registers.
  - Latency from accepted push into an empty FIFO to valid rdata: 1 cycle.
- No state machine beyond pointer/count registers; the count register replaces full/empty next-state logic.
- Target: ~150 lines of RTL.

Test Plan (DATA_WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1):
- Reset with push=1, wdata=8'hAA held during reset -> count=0, empty=1, almost_empty=1, full=0, rdata=0; no write after reset release unless push is sampled.
- Push 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles:
  - count steps 1,2,3,4.
  - almost_empty drops when count=2.
  - almost_full rises when count=3.
  - full=1 at count=4.
  - rdata=8'h11 from the cycle after the first push.
- At full, push 8'h55 alone -> rejected, overflow=1, count=4. Then pop four times -> rdata 11,22,33,44 in order, empty=1, rdata=0.
- At full (11..44 queued), push 8'h55 with pop for one cycle -> count stays 4. rdata becomes 8'h22. The subsequent drain yields 22,33,44,55.
- Empty FIFO, push 8'h66 with pop -> underflow=1, count=1, rdata=8'h66 next cycle. Then clr_err=1 for one cycle -> underflow=0; overflow unaffected unless also set.
- Pointer wrap: 10 push/pop pairs with one entry resident -> data order preserved across wrap, count constant 1. Apply rst mid-stream -> count=0, empty=1 the next cycle.

Source files
------------

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer handshake bundle for fifo_sync_param.
interface fifo_sync_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  push;
  logic                  pop;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, pop, clr_err, wdata,
    input  rdata, count, full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  push, pop, clr_err, wdata,
    output rdata, count, full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy count, almost flags, sticky error flags
// and show-ahead read data. Push is accepted at full when a pop frees a slot.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input logic               clk_i,
  input logic               rst_i,
  fifo_sync_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full, empty;
  logic                  push_ok, pop_ok;

  // Flags come only from the registered count.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A pop at full frees the slot the push lands in on the same edge.
  assign push_ok = bus.push & (~full | bus.pop);
  assign pop_ok  = bus.pop & ~empty;

  // Next-state for pointers, occupancy and sticky errors.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A fresh error in the clearing cycle still sets the flag.
    ovf_d = (bus.clr_err ? 1'b0 : ovf_q) | (bus.push & ~push_ok);
    udf_d = (bus.clr_err ? 1'b0 : udf_q) | (bus.pop  & ~pop_ok);
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is not reset; writes are blocked during reset.
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i) mem_q[wptr_q] <= bus.wdata;
  end

  assign bus.rdata        = empty ? '0 : mem_q[rptr_q];
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Vector-table bench for fifo_sync_param with a data scoreboard queue.
module tb_fifo_sync_param;
  localparam int DW = 8;
  localparam int DP = 4;

  typedef struct {
    logic       rst;
    logic       push;
    logic       pop;
    logic       clr;
    logic [7:0] wdata;
    int         cnt;
    logic [7:0] rd;
    logic       ovf;
    logic       udf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t vt[$];
  logic [7:0] sb[$];

  fifo_sync_param_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic pu, input logic po, input logic cl,
                     input logic [7:0] wd, input int c, input logic [7:0] rd,
                     input logic ov, input logic ud);
    vec_t v;
    v.rst = r; v.push = pu; v.pop = po; v.clr = cl; v.wdata = wd;
    v.cnt = c; v.rd = rd; v.ovf = ov; v.udf = ud;
    vt.push_back(v);
  endtask

  initial begin
    int prev;
    int sz;
    logic [7:0] exp_head;
    rst = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0; bus.wdata = '0;

    // rst push pop clr wdata cnt rdata ovf udf
    add(1, 1, 0, 0, 8'hAA, 0, 8'h00, 0, 0);
    add(1, 1, 0, 0, 8'hAA, 0, 8'h00, 0, 0);
    add(0, 0, 0, 0, 8'hAA, 0, 8'h00, 0, 0);
    add(0, 1, 0, 0, 8'h11, 1, 8'h11, 0, 0);
    add(0, 1, 0, 0, 8'h22, 2, 8'h11, 0, 0);
    add(0, 1, 0, 0, 8'h33, 3, 8'h11, 0, 0);
    add(0, 1, 0, 0, 8'h44, 4, 8'h11, 0, 0);
    add(0, 1, 0, 0, 8'h55, 4, 8'h11, 1, 0);   // rejected at full
    add(0, 0, 1, 0, 8'h00, 3, 8'h22, 1, 0);
    add(0, 0, 1, 0, 8'h00, 2, 8'h33, 1, 0);
    add(0, 0, 1, 0, 8'h00, 1, 8'h44, 1, 0);
    add(0, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0);
    add(0, 1, 0, 0, 8'h11, 1, 8'h11, 1, 0);
    add(0, 1, 0, 0, 8'h22, 2, 8'h11, 1, 0);
    add(0, 1, 0, 0, 8'h33, 3, 8'h11, 1, 0);
    add(0, 1, 0, 0, 8'h44, 4, 8'h11, 1, 0);
    add(0, 1, 1, 0, 8'h55, 4, 8'h22, 1, 0);   // push+pop at full
    add(0, 0, 1, 0, 8'h00, 3, 8'h33, 1, 0);
    add(0, 0, 1, 0, 8'h00, 2, 8'h44, 1, 0);
    add(0, 0, 1, 0, 8'h00, 1, 8'h55, 1, 0);
    add(0, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0);
    add(0, 1, 1, 0, 8'h66, 1, 8'h66, 1, 1);   // push+pop at empty
    add(0, 0, 0, 1, 8'h00, 1, 8'h66, 0, 0);
    add(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1);   // pop at empty
    add(0, 0, 1, 1, 8'h00, 0, 8'h00, 0, 1);   // new error beats clear
    add(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
    add(0, 1, 0, 0, 8'h70, 1, 8'h70, 0, 0);
    for (int k = 0; k < 10; k++)
      add(0, 1, 1, 0, 8'(8'h71 + k), 1, 8'(8'h71 + k), 0, 0);
    add(1, 1, 0, 0, 8'hBB, 0, 8'h00, 0, 0);   // reset mid-stream
    add(0, 1, 0, 0, 8'h99, 1, 8'h99, 0, 0);

    prev = 0;
    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].rst; bus.push = vt[i].push; bus.pop = vt[i].pop;
      bus.clr_err = vt[i].clr; bus.wdata = vt[i].wdata;
      #1;
      // Request lines must not reach count before the edge.
      if (i > 0) chk("hold_count", int'(bus.count), prev);
      sz = sb.size();
      if (vt[i].rst) sb.delete();
      else begin
        if (vt[i].pop && sz > 0) begin
          exp_head = sb.pop_front();
          chk("pop_data", int'(bus.rdata), int'(exp_head));
        end
        if (vt[i].push && (sz < DP || vt[i].pop)) sb.push_back(vt[i].wdata);
      end
      @(posedge clk); #1;
      chk("count", int'(bus.count), vt[i].cnt);
      chk("rdata", int'(bus.rdata), int'(vt[i].rd));
      chk("sb_depth", int'(bus.count), sb.size());
      chk("full", int'(bus.full), int'(vt[i].cnt == DP));
      chk("empty", int'(bus.empty), int'(vt[i].cnt == 0));
      chk("almost_full", int'(bus.almost_full), int'(vt[i].cnt >= 3));
      chk("almost_empty", int'(bus.almost_empty), int'(vt[i].cnt <= 1));
      chk("overflow", int'(bus.overflow), int'(vt[i].ovf));
      chk("underflow", int'(bus.underflow), int'(vt[i].udf));
      prev = vt[i].cnt;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
